// File: rtl/write_select_pkg.sv
// Shared types for the register-file write-select decoder: FSM states, mode
// encoding and the pipeline slot carried between stages.
package write_select_pkg;

    // Slot address field is wide enough for any supported ADDR_W; narrower
    // addresses are zero-extended on entry.
    localparam int unsigned SLOT_ADDR_W = 16;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_HOLD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HELD   = 2'd2
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] addr;
        logic                   enable;
        logic                   mode;
    } slot_t;

endpackage

// File: rtl/decoder_stage.sv
// Combinational address-to-one-hot decoder with enable; at most one bit set.
module decoder_stage
    import write_select_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic [SLOT_ADDR_W-1:0] addr,
    input  logic                   enable,
    output logic [OUT_W-1:0]       sel
);

    for (genvar i = 0; i < OUT_W; i++) begin : g_dec
        assign sel[i] = enable && (addr == SLOT_ADDR_W'(i));
    end

endmodule

// File: rtl/write_select_decoder.sv
// Pipelined one-hot write-select generator with valid/ready input, pulse/hold
// output modes, optional index-0 protection and a saturating drop counter.
module write_select_decoder
    import write_select_pkg::*;
#(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned ZERO_PROTECT = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic                    in_enable,
    input  logic                    hold_mode,
    input  logic                    clear,
    input  logic                    stall,
    output logic [(2**ADDR_W)-1:0]  out_sel,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int unsigned OUT_W = 2**ADDR_W;
    localparam logic        ZP    = (ZERO_PROTECT != 0);

    slot_t              acc_slot;
    slot_t              dec_slot;
    logic [OUT_W-1:0]   dec_sel;
    logic               dec_is_zero;
    logic               dec_suppress;
    state_t             state_q;
    state_t             state_d;
    logic [OUT_W-1:0]   sel_d;
    logic               valid_d;
    logic [CNT_W-1:0]   cnt_d;

    assign in_ready = ~stall & ~ctrl_reset;

    always_comb begin
        acc_slot.valid  = in_valid & in_ready;
        acc_slot.addr   = SLOT_ADDR_W'(in_addr);
        acc_slot.enable = in_enable;
        acc_slot.mode   = hold_mode;
    end

    // Holding stages ahead of the decode stage; none when LATENCY is 1.
    if (LATENCY > 1) begin : g_pipe
        slot_t pipe_q [LATENCY-1];

        always_ff @(posedge clock) begin
            if (ctrl_reset) begin
                for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (!stall) begin
                pipe_q[0] <= acc_slot;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign dec_slot = pipe_q[LATENCY-2];
    end else begin : g_nopipe
        assign dec_slot = acc_slot;
    end

    assign dec_is_zero  = (dec_slot.addr == '0);
    assign dec_suppress = dec_slot.valid & dec_slot.enable & ZP & dec_is_zero;

    decoder_stage #(
        .OUT_W (OUT_W)
    ) u_decoder_stage (
        .addr   (dec_slot.addr),
        .enable (dec_slot.enable & ~(ZP & dec_is_zero)),
        .sel    (dec_sel)
    );

    // Decode-stage FSM next state; everything holds while stalled.
    always_comb begin
        state_d = state_q;
        sel_d   = out_sel;
        valid_d = out_valid;
        cnt_d   = drop_cnt;
        if (!stall) begin
            valid_d = dec_slot.valid;
            if (dec_slot.valid) begin
                sel_d   = dec_sel;
                state_d = (dec_slot.mode == MODE_PULSE) ? ACTIVE : HELD;
                if (dec_suppress && (drop_cnt != '1)) begin
                    cnt_d = drop_cnt + CNT_W'(1);
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        sel_d = '0;
                    end
                    ACTIVE: begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                    HELD: begin
                        if (clear) begin
                            sel_d   = '0;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q   <= IDLE;
            out_sel   <= '0;
            out_valid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            out_sel   <= sel_d;
            out_valid <= valid_d;
            drop_cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_write_select_decoder.sv
// Directed self-checking bench for write_select_decoder (ADDR_W=5, LATENCY=2).
module tb_write_select_decoder;
    import write_select_pkg::*;

    logic        clock;
    logic        ctrl_reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic        in_enable;
    logic        hold_mode;
    logic        clear;
    logic        stall;
    logic [31:0] out_sel;
    logic        out_valid;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    write_select_decoder #(
        .ADDR_W       (5),
        .LATENCY      (2),
        .ZERO_PROTECT (1),
        .CNT_W        (8)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_enable  (in_enable),
        .hold_mode  (hold_mode),
        .clear      (clear),
        .stall      (stall),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .drop_cnt   (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [4:0] a, input logic en, input logic md);
        in_valid  = 1'b1;
        in_addr   = a;
        in_enable = en;
        hold_mode = md;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        in_valid   = 1'b1;
        in_addr    = 5'd5;
        in_enable  = 1'b1;
        hold_mode  = MODE_PULSE;
        clear      = 1'b0;
        stall      = 1'b0;
        #1;
        chk("reset_ready_comb", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("reset_sel", 64'(out_sel), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_cnt", 64'(drop_cnt), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd0);
        ctrl_reset = 1'b0;
        in_valid   = 1'b0;
        tick();

        // Pulse, addr 5: visible two cycles after accept, for one cycle only
        req(5'd5, 1'b1, MODE_PULSE);
        chk("pulse_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("pulse_c1_valid", 64'(out_valid), 64'd0);
        chk("pulse_c1_sel", 64'(out_sel), 64'd0);
        tick();
        chk("pulse_c2_sel", 64'(out_sel), 64'h20);
        chk("pulse_c2_valid", 64'(out_valid), 64'd1);
        tick();
        chk("pulse_c3_sel", 64'(out_sel), 64'd0);
        chk("pulse_c3_valid", 64'(out_valid), 64'd0);

        // Hold addr 31, persists, then clear
        req(5'd31, 1'b1, MODE_HOLD);
        tick();
        in_valid = 1'b0;
        tick();
        chk("hold_first_sel", 64'(out_sel), 64'h8000_0000);
        chk("hold_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold_persist_sel", 64'(out_sel), 64'h8000_0000);
            chk("hold_persist_valid", 64'(out_valid), 64'd0);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("hold_clear_sel", 64'(out_sel), 64'd0);
        tick();
        chk("idle_after_clear", 64'(out_sel), 64'd0);

        // Zero protect: 300 back-to-back addr 0 requests
        for (int i = 0; i < 302; i++) begin
            if (i < 300) req(5'd0, 1'b1, MODE_PULSE);
            else in_valid = 1'b0;
            tick();
            chk("zp_sel", 64'(out_sel), 64'd0);
            if (i == 1) begin
                chk("zp_first_valid", 64'(out_valid), 64'd1);
                chk("zp_first_cnt", 64'(drop_cnt), 64'd1);
            end
        end
        chk("zp_cnt_sat", 64'(drop_cnt), 64'hFF);

        // Stall with addr 3 mid-pipeline
        req(5'd3, 1'b1, MODE_PULSE);
        tick();
        in_valid = 1'b0;
        stall    = 1'b1;
        #1;
        chk("stall_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_frozen_valid", 64'(out_valid), 64'd0);
            chk("stall_frozen_sel", 64'(out_sel), 64'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_sel", 64'(out_sel), 64'h8);
        chk("stall_release_valid", 64'(out_valid), 64'd1);
        tick();
        chk("stall_after_sel", 64'(out_sel), 64'd0);

        // Stall stretches a live pulse
        req(5'd4, 1'b1, MODE_PULSE);
        tick();
        in_valid = 1'b0;
        tick();
        chk("stretch_sel", 64'(out_sel), 64'h10);
        stall = 1'b1;
        tick();
        tick();
        chk("stretch_held_sel", 64'(out_sel), 64'h10);
        chk("stretch_held_valid", 64'(out_valid), 64'd1);
        stall = 1'b0;
        tick();
        chk("stretch_end_sel", 64'(out_sel), 64'd0);
        chk("stretch_end_valid", 64'(out_valid), 64'd0);

        // Disabled request: consumes a slot with zero select
        req(5'd7, 1'b0, MODE_PULSE);
        tick();
        in_valid = 1'b0;
        tick();
        chk("disabled_sel", 64'(out_sel), 64'd0);
        chk("disabled_valid", 64'(out_valid), 64'd1);

        // Clear and request on the same edge: request wins
        req(5'd9, 1'b1, MODE_HOLD);
        tick();
        in_valid = 1'b0;
        tick();
        chk("hold9_sel", 64'(out_sel), 64'h200);
        req(5'd10, 1'b1, MODE_PULSE);
        tick();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_vs_req_sel", 64'(out_sel), 64'h400);
        chk("clear_vs_req_valid", 64'(out_valid), 64'd1);
        tick();
        chk("clear_vs_req_after", 64'(out_sel), 64'd0);

        // Back-to-back addrs 1,2,3
        req(5'd1, 1'b1, MODE_PULSE);
        tick();
        req(5'd2, 1'b1, MODE_PULSE);
        tick();
        chk("b2b_sel1", 64'(out_sel), 64'h2);
        chk("b2b_valid1", 64'(out_valid), 64'd1);
        req(5'd3, 1'b1, MODE_PULSE);
        tick();
        in_valid = 1'b0;
        chk("b2b_sel2", 64'(out_sel), 64'h4);
        chk("b2b_valid2", 64'(out_valid), 64'd1);
        tick();
        chk("b2b_sel3", 64'(out_sel), 64'h8);
        chk("b2b_valid3", 64'(out_valid), 64'd1);
        tick();
        chk("b2b_end_valid", 64'(out_valid), 64'd0);

        // Reset while addr 2 is in flight
        req(5'd1, 1'b1, MODE_PULSE);
        tick();
        req(5'd2, 1'b1, MODE_PULSE);
        tick();
        chk("rst_flight_sel1", 64'(out_sel), 64'h2);
        in_valid   = 1'b0;
        ctrl_reset = 1'b1;
        #1;
        chk("rst_flight_ready", 64'(in_ready), 64'd0);
        tick();
        chk("rst_flight_sel", 64'(out_sel), 64'd0);
        chk("rst_flight_valid", 64'(out_valid), 64'd0);
        chk("rst_flight_cnt", 64'(drop_cnt), 64'd0);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_flight_no_valid", 64'(out_valid), 64'd0);
            chk("rst_flight_no_sel", 64'(out_sel), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
